// File: rtl/uart_pkg.sv
// Shared definitions for the UART response transmitter and the sensor-connection block:
// FSM state encoding and the response code constants exchanged between them.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_START = START,
        S_DATA  = DATA,
        S_STOP  = STOP
    } tx_state_t;

    // Response codes produced by the sensor-connection block.
    localparam logic [7:0] RESP_CODE_07 = 8'h07;
    localparam logic [7:0] RESP_CODE_08 = 8'h08;
    localparam logic [7:0] RESP_CODE_09 = 8'h09;
    localparam logic [7:0] RESP_CODE_0A = 8'h0A;
    localparam logic [7:0] RESP_CODE_0B = 8'h0B;
    localparam logic [7:0] RESP_CODE_0D = 8'h0D;
    localparam logic [7:0] RESP_CODE_0E = 8'h0E;
    localparam logic [7:0] RESP_CODE_1F = 8'h1F;
    localparam logic [7:0] RESP_CODE_45 = 8'h45;
    localparam logic [7:0] RESP_CODE_AA = 8'hAA;
    localparam logic [7:0] RESP_CODE_AB = 8'hAB;
    localparam logic [7:0] RESP_CODE_FF = 8'hFF;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: emits a one-cycle tick on the last clock of every CLKS_PER_BIT window.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // clear restarts the window so a freshly triggered start bit gets its full length.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_response_tx.sv
// Sends the (command, value) response pair as two back-to-back 8N1 frames, command first,
// on each rising edge of send; reports busy, a done pulse, and an overrun pulse.
module uart_response_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] response_command,
    input  logic [7:0] response_value,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    tx_state_t  state;
    logic       send_d;
    logic       send_edge;
    logic       baud_clear;
    logic       bit_tick;
    logic [2:0] bit_idx;
    logic [2:0] next_bit;
    logic       byte_idx;
    logic [7:0] cmd_r;
    logic [7:0] val_r;
    logic [7:0] cur_byte;

    // send is a level/strobe with no ready: only its rising edge requests a transfer, and an
    // edge seen while busy is dropped and flagged on overrun rather than queued.
    assign send_edge  = send & ~send_d;
    assign baud_clear = (state == S_IDLE) && send_edge;
    assign cur_byte   = byte_idx ? val_r : cmd_r;
    assign next_bit   = bit_idx + 3'd1;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clock(clock),
        .reset(reset),
        .clear(baud_clear),
        .tick (bit_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            bit_idx  <= 3'd0;
            byte_idx <= 1'b0;
            send_d   <= 1'b1;
            cmd_r    <= 8'h00;
            val_r    <= 8'h00;
        end else begin
            send_d  <= send;
            done    <= 1'b0;
            overrun <= send_edge && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (send_edge) begin
                        cmd_r    <= response_command;
                        val_r    <= response_value;
                        byte_idx <= 1'b0;
                        state    <= S_START;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        state   <= S_DATA;
                        bit_idx <= 3'd0;
                        tx      <= cur_byte[0];
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= next_bit;
                            tx      <= cur_byte[next_bit];
                        end
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        if (!byte_idx) begin
                            // Second frame follows immediately; no idle gap on the line.
                            byte_idx <= 1'b1;
                            state    <= S_START;
                            tx       <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
